spike_decompressor_temporal: RTL
================================

Name: spike_decompressor_temporal

Overview:
Temporal spike decompressor for the TPPE path. It accepts a T_WINDOW-bit compressed spike history and replays it as a serial per-timestep spike stream under a valid/ready handshake. Bit order is oldest-first: MSB, then down to LSB, which matches the left-shift, newest-in-LSB packing of the temporal compressor. It sits between pattern storage/transport and the per-timestep LIF neuron inputs.

Parameters:
T_WINDOW, 16, number of timesteps per compressed pattern. Legal range is 2 or more.
CNT_W, $clog2(T_WINDOW+1), width of the spike count and timestep index fields.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
pattern_in  input  T_WINDOW  compressed pattern. Bit T_WINDOW-1 is the oldest timestep; bit 0 is the newest.
pattern_valid  input  1  pattern_in is valid
pattern_ready  output  1  block can accept a pattern this cycle
spike_out  output  1  spike value for the current timestep
spike_valid  output  1  spike_out, t_idx and t_last are valid
spike_ready  input  1  downstream consumes the current timestep
t_idx  output  CNT_W  timestep index of spike_out, from 0 to T_WINDOW-1
t_last  output  1  high when t_idx equals T_WINDOW-1
frame_done  output  1  one-cycle pulse when the last timestep of a pattern is consumed
frame_spike_cnt  output  CNT_W  number of 1s in the most recently completed pattern. Held until the next completion.

Behaviour:
- Reset (rst_n low at a clock edge) returns the block to IDLE and clears all outputs:
  - shift register = 0, t_idx = 0, spike_valid = 0, t_last = 0, spike_out = 0.
  - frame_done = 0, frame_spike_cnt = 0, running count = 0.
  - A reset mid-replay discards the pattern with no frame_done.
- States: IDLE and REPLAY.
- pattern_ready = (state == IDLE) OR (spike_valid AND spike_ready AND t_last). This is combinational and allows back-to-back patterns with no bubble.
- Load: a pattern is accepted when pattern_valid and pattern_ready are both high.
  - On the next cycle: state = REPLAY, shift register = pattern_in, spike_valid = 1, t_idx = 0, running count cleared.
  - spike_out = shreg[T_WINDOW-1]. Latency from accept to first spike_valid is 1 cycle.
- Beat: a beat occurs when spike_valid and spike_ready are both high.
  - Shift register shifts left by one and fills with 0.
  - t_idx increments.
  - Running count adds spike_out.
  - With no beat, all outputs hold (stall). spike_out, t_idx and t_last must not change while spike_valid is high and spike_ready is low.
- Last beat (beat with t_last = 1):
  - frame_done is 1 on the next cycle.
  - frame_spike_cnt = running count + spike_out.
  - If a new pattern is accepted in the same cycle: stay in REPLAY with t_idx = 0 and load the new pattern.
  - Otherwise: go to IDLE with spike_valid = 0 and t_idx = 0.
- frame_done is high for exactly one cycle per completed pattern. frame_spike_cnt is updated only when frame_done is asserted.
- pattern_valid while not ready: the pattern is ignored (not latched). The upstream side holds it.
- The all-zero pattern still replays T_WINDOW beats with spike_out = 0 and gives frame_spike_cnt = 0. The all-ones pattern gives frame_spike_cnt = T_WINDOW, which must not overflow CNT_W.
- Throughput is 1 timestep per cycle with spike_ready held high. Sustained rate is T_WINDOW cycles per pattern.

Test Plan:
- Reset, then a single pattern with T_WINDOW = 16, pattern_in = 16'hA001, spike_ready = 1.
  - spike_out sequence 1,0,1,0,0,0,0,0,0,0,0,0,0,0,0,1 on t_idx 0..15.
  - First spike_valid 1 cycle after accept; t_last only at t_idx = 15.
  - frame_done pulses once; frame_spike_cnt = 3; block returns to IDLE with pattern_ready = 1.
- Back-to-back patterns: 16'hFFFF then 16'h0000, pattern_valid held, spike_ready = 1.
  - 32 consecutive spike_valid cycles with no gap; pattern_ready is high on the t_last beat.
  - frame_spike_cnt = 16, then 0; two frame_done pulses 16 cycles apart.
- Backpressure: pattern 16'h8000, spike_ready toggling 1,0,0,1,...
  - spike_out, t_idx and t_last are stable during stalls.
  - Exactly 16 beats; only the t_idx = 0 beat has spike_out = 1; frame_spike_cnt = 1.
- Pattern offered while busy: pattern_valid pulsed for 1 cycle at t_idx = 5 with value 16'h1234.
  - Not accepted and not replayed; the current pattern completes unaffected.
- Reset mid-replay: rst_n low for 1 cycle at t_idx = 7.
  - Next cycle: spike_valid = 0, t_idx = 0, no frame_done.
  - frame_spike_cnt = 0; pattern_ready = 1 after release.
- Compressor round-trip: drive the temporal compressor with 16 random spikes, then feed its pattern here.
  - The replayed spike_out stream equals the original spike stream in the same order.

Source files
------------

// File: rtl/spike_decompressor_temporal.sv
// Temporal spike decompressor: replays a T_WINDOW-bit compressed spike history
// as a serial per-timestep spike stream, oldest timestep (MSB) first.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   pattern_in        compressed pattern, bit T_WINDOW-1 oldest, bit 0 newest
//   pattern_valid     pattern_in valid
//   pattern_ready     block can accept a pattern this cycle (combinational)
//   spike_out         spike for the current timestep
//   spike_valid       spike_out / t_idx / t_last valid
//   spike_ready       downstream consumes the current timestep
//   t_idx             timestep index of spike_out
//   t_last            current timestep is the final one of the pattern
//   frame_done        one-cycle pulse after the last timestep is consumed
//   frame_spike_cnt   number of ones in the most recently completed pattern
module spike_decompressor_temporal #(
    parameter int unsigned T_WINDOW = 16,
    parameter int unsigned CNT_W    = $clog2(T_WINDOW + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [T_WINDOW-1:0] pattern_in,
    input  logic                pattern_valid,
    output logic                pattern_ready,
    output logic                spike_out,
    output logic                spike_valid,
    input  logic                spike_ready,
    output logic [CNT_W-1:0]    t_idx,
    output logic                t_last,
    output logic                frame_done,
    output logic [CNT_W-1:0]    frame_spike_cnt
);

    localparam logic [CNT_W-1:0] PRE_LAST_IDX = CNT_W'(T_WINDOW - 2);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REPLAY = 1'b1
    } state_e;

    state_e              state_q,       state_d;
    logic [T_WINDOW-1:0] shreg_q,       shreg_d;
    logic [CNT_W-1:0]    t_idx_q,       t_idx_d;
    logic                t_last_q,      t_last_d;
    logic                spike_valid_q, spike_valid_d;
    logic [CNT_W-1:0]    run_cnt_q,     run_cnt_d;
    logic                frame_done_q,  frame_done_d;
    logic [CNT_W-1:0]    frame_cnt_q,   frame_cnt_d;

    logic beat_c;
    logic last_beat_c;
    logic load_c;

    // Handshake decode; ready also opens on the final beat so patterns chain without a bubble
    assign beat_c        = spike_valid_q & spike_ready;
    assign last_beat_c   = beat_c & t_last_q;
    assign pattern_ready = (state_q == ST_IDLE) | last_beat_c;
    assign load_c        = pattern_valid & pattern_ready;

    // State and datapath register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            t_idx_q       <= '0;
            t_last_q      <= 1'b0;
            spike_valid_q <= 1'b0;
            run_cnt_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            t_idx_q       <= t_idx_d;
            t_last_q      <= t_last_d;
            spike_valid_q <= spike_valid_d;
            run_cnt_q     <= run_cnt_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // Next-state: hold by default, advance on a beat, close on the last beat, then load overrides
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        t_idx_d       = t_idx_q;
        t_last_d      = t_last_q;
        spike_valid_d = spike_valid_q;
        run_cnt_d     = run_cnt_q;
        frame_done_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;

        if (beat_c) begin
            shreg_d   = {shreg_q[T_WINDOW-2:0], 1'b0};
            t_idx_d   = CNT_W'(t_idx_q + CNT_W'(1));
            t_last_d  = (t_idx_q == PRE_LAST_IDX);
            run_cnt_d = CNT_W'(run_cnt_q + CNT_W'(shreg_q[T_WINDOW-1]));
        end

        if (last_beat_c) begin
            frame_done_d  = 1'b1;
            frame_cnt_d   = CNT_W'(run_cnt_q + CNT_W'(shreg_q[T_WINDOW-1]));
            state_d       = ST_IDLE;
            spike_valid_d = 1'b0;
            t_idx_d       = '0;
            t_last_d      = 1'b0;
            run_cnt_d     = '0;
        end

        if (load_c) begin
            state_d       = ST_REPLAY;
            shreg_d       = pattern_in;
            spike_valid_d = 1'b1;
            t_idx_d       = '0;
            t_last_d      = 1'b0;
            run_cnt_d     = '0;
        end
    end

    assign spike_out       = shreg_q[T_WINDOW-1];
    assign spike_valid     = spike_valid_q;
    assign t_idx           = t_idx_q;
    assign t_last          = t_last_q;
    assign frame_done      = frame_done_q;
    assign frame_spike_cnt = frame_cnt_q;

endmodule
